addsub_normalize: RTL and testbench

Multi-cycle normalize-and-round stage of the single-precision add/sub datapath. It takes the raw significand sum, exponent and special-case code from the align/add stage. It normalizes by iterative shifting, one bit per cycle, and rounds to nearest-even. It then hands the result to the final error-check/packing stage over a valid/ready handshake.

---
 rtl/addpkg.sv | 22 ++
 rtl/addsub_normalize.sv | 186 ++++++++++++++++++
 tb/tb_addsub_normalize.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/addpkg.sv
// Shared special-case codes for the single-precision add/sub datapath.
package addpkg;

  // Special-case code carried from the align/add stage.
  typedef enum logic [2:0] {
    NO_ERR      = 3'd0,
    ZERO_OP_ERR = 3'd1,
    INF_ERR     = 3'd2,
    NAN_ERR     = 3'd3,
    ZERO_ERR    = 3'd4
  } i_err_t;

  // Final error classification produced by the packing stage.
  typedef enum logic [2:0] {
    O_OK        = 3'd0,
    O_INEXACT   = 3'd1,
    O_OVERFLOW  = 3'd2,
    O_UNDERFLOW = 3'd3,
    O_INVALID   = 3'd4
  } o_err_t;

endpackage

// File: rtl/addsub_normalize.sv
// Normalize-and-round stage of the single-precision add/sub datapath.
// Normalizes the raw significand sum one bit per cycle, then rounds to
// nearest-even. The result is presented on a valid/ready handshake.
module addsub_normalize
  import addpkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [27:0] sum_i,
  input  i_err_t      err_i,
  input  logic [30:0] nz_op_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_o,
  output logic [7:0]  exp_o,
  output logic [26:0] sig_untrunc_o,
  output logic        carry_o,
  output logic [30:0] nz_op_o,
  output i_err_t      err_o
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [27:0] sig_q, sig_d;
  logic [8:0]  exp_q, exp_d;
  i_err_t      err_q, err_d;
  logic        sign_q, sign_d;
  logic [30:0] nz_q, nz_d;
  logic        carry_q, carry_d;
  logic [24:0] rnd;
  logic        load_out;

  logic        out_valid_q;
  logic        sign_o_q;
  logic [7:0]  exp_o_q;
  logic [26:0] sig_o_q;
  logic        carry_o_q;
  logic [30:0] nz_o_q;
  i_err_t      err_o_q;

  // Round-to-nearest-even decision: guard set and any of round/sticky/LSB.
  function automatic logic rne_up(input logic [27:0] s);
    return s[2] & (s[1] | s[0] | s[3]);
  endfunction

  // Upstream codes that bypass normalization entirely.
  function automatic logic is_special(input i_err_t e);
    return (e == ZERO_OP_ERR) || (e == INF_ERR) || (e == NAN_ERR) || (e == ZERO_ERR);
  endfunction

  // Next-state and datapath computation for the normalize/round FSM.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    err_d   = err_q;
    sign_d  = sign_q;
    nz_d    = nz_q;
    carry_d = carry_q;
    rnd     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sig_d   = sum_i;
          exp_d   = (exp_i == 8'd0) ? 9'd1 : {1'b0, exp_i};
          err_d   = err_i;
          sign_d  = sign_i;
          nz_d    = nz_op_i;
          carry_d = 1'b0;
          if (is_special(err_i)) begin
            state_d = DONE;
          end else if (sum_i == 28'd0) begin
            err_d   = ZERO_ERR;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (sig_q[27]) begin
          // Carry out of the add: shift right, folding the lost bit into sticky.
          sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + 9'd1;
          if (exp_d >= 9'd255) begin
            err_d   = INF_ERR;
            state_d = DONE;
          end else begin
            state_d = ROUND;
          end
        end else if (sig_q[26]) begin
          state_d = ROUND;
        end else if (exp_q == 9'd1) begin
          // Cannot shift further without going below the minimum exponent.
          exp_d   = 9'd0;
          state_d = ROUND;
        end else begin
          sig_d = {sig_q[26:0], 1'b0};
          exp_d = exp_q - 9'd1;
        end
      end
      ROUND: begin
        if (rne_up(sig_q)) begin
          rnd = {1'b0, sig_q[26:3]} + 25'd1;
          if (rnd[24]) begin
            // Rounding overflowed the significand; GRS keep pre-round values.
            sig_d   = {1'b0, rnd[24:1], sig_q[2:0]};
            exp_d   = exp_q + 9'd1;
            carry_d = 1'b1;
            if (exp_d >= 9'd255) err_d = INF_ERR;
          end else begin
            sig_d = {rnd, sig_q[2:0]};
            // A denormal that rounds up into the hidden bit becomes normal.
            if ((exp_q == 9'd0) && rnd[23]) exp_d = 9'd1;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_out = (state_d == DONE) && (state_q != DONE);

  // FSM and working registers; reset abandons any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      exp_q   <= '0;
      err_q   <= ZERO_ERR;
      sign_q  <= 1'b0;
      nz_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      sign_q  <= sign_d;
      nz_q    <= nz_d;
      carry_q <= carry_d;
    end
  end

  // Output registers load only on entry to DONE so they stay still while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sign_o_q    <= 1'b0;
      exp_o_q     <= '0;
      sig_o_q     <= '0;
      carry_o_q   <= 1'b0;
      nz_o_q      <= '0;
      err_o_q     <= ZERO_ERR;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      sign_o_q    <= sign_d;
      exp_o_q     <= exp_d[7:0];
      sig_o_q     <= sig_d[26:0];
      carry_o_q   <= carry_d;
      nz_o_q      <= nz_d;
      err_o_q     <= err_d;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = out_valid_q;
  assign sign_o        = sign_o_q;
  assign exp_o         = exp_o_q;
  assign sig_untrunc_o = sig_o_q;
  assign carry_o       = carry_o_q;
  assign nz_op_o       = nz_o_q;
  assign err_o         = err_o_q;

endmodule

// File: tb/tb_addsub_normalize.sv
// Directed testbench for addsub_normalize with a queue-based scoreboard.
module tb_addsub_normalize;
  import addpkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [27:0] sum_i;
  i_err_t      err_i;
  logic [30:0] nz_op_i;
  logic        out_valid;
  logic        out_ready;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [26:0] sig_untrunc_o;
  logic        carry_o;
  logic [30:0] nz_op_o;
  i_err_t      err_o;

  always #5 clk = ~clk;

  addsub_normalize dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sign_i        (sign_i),
    .exp_i         (exp_i),
    .sum_i         (sum_i),
    .err_i         (err_i),
    .nz_op_i       (nz_op_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sign_o        (sign_o),
    .exp_o         (exp_o),
    .sig_untrunc_o (sig_untrunc_o),
    .carry_o       (carry_o),
    .nz_op_o       (nz_op_o),
    .err_o         (err_o)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] sig;
    logic        carry;
    logic [30:0] nz;
    i_err_t      err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".sign"},  64'(sign_o),        64'(e.sign));
    chk({tag, ".exp"},   64'(exp_o),         64'(e.exp));
    chk({tag, ".sig"},   64'(sig_untrunc_o), 64'(e.sig));
    chk({tag, ".carry"}, 64'(carry_o),       64'(e.carry));
    chk({tag, ".nz_op"}, 64'(nz_op_o),       64'(e.nz));
    chk({tag, ".err"},   64'(err_o),         64'(e.err));
  endtask

  // One transaction: drive, push expectation, wait for result, compare, drain.
  task automatic run(input string tag, input logic s, input logic [7:0] ex,
                     input logic [27:0] sm, input i_err_t er, input logic [30:0] nz,
                     input logic [7:0] e_exp, input logic [26:0] e_sig, input logic e_c,
                     input i_err_t e_err, input int lat, input int hold);
    exp_t e;
    exp_t got;
    int   k;
    e = '{s, e_exp, e_sig, e_c, nz, e_err, lat};
    out_ready = (hold == 0);
    chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    sign_i   = s;
    exp_i    = ex;
    sum_i    = sm;
    err_i    = er;
    nz_op_i  = nz;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    got = sb.pop_front();
    chk({tag, ".latency"}, 64'(k), 64'(got.lat));
    check_outs(tag, got);
    for (int i = 0; i < hold; i++) begin
      // Busy-time input activity must be ignored.
      in_valid = 1'b1;
      sum_i    = 28'($urandom);
      exp_i    = 8'($urandom);
      @(negedge clk);
      check_outs({tag, ".hold"}, got);
      chk({tag, ".hold.in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".in_ready_post"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid_post"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sign_i    = 1'b0;
    exp_i     = '0;
    sum_i     = '0;
    err_i     = NO_ERR;
    nz_op_i   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sign",  64'(sign_o),        64'd0);
    chk("rst.exp",   64'(exp_o),         64'd0);
    chk("rst.sig",   64'(sig_untrunc_o), 64'd0);
    chk("rst.carry", 64'(carry_o),       64'd0);
    chk("rst.nz_op", 64'(nz_op_o),       64'd0);
    chk("rst.err",   64'(err_o),         64'(ZERO_ERR));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    run("one_plus_one", 1'b1, 8'd127, 28'h8000000, NO_ERR, 31'h1,
        8'd128, 27'h4000000, 1'b0, NO_ERR, 3, 0);
    run("cancel", 1'b0, 8'd130, 28'h0000008, NO_ERR, 31'h2,
        8'd107, 27'h4000000, 1'b0, NO_ERR, 26, 0);
    run("tie_odd", 1'b0, 8'd127, 28'h7FFFFFC, NO_ERR, 31'h3,
        8'd128, 27'h4000004, 1'b1, NO_ERR, 3, 0);
    run("tie_even", 1'b0, 8'd127, 28'h4000004, NO_ERR, 31'h4,
        8'd127, 27'h4000004, 1'b0, NO_ERR, 3, 0);
    run("norm_ovf", 1'b0, 8'd254, 28'h8000000, NO_ERR, 31'h5,
        8'd255, 27'h4000000, 1'b0, INF_ERR, 2, 0);
    run("round_ovf", 1'b1, 8'd254, 28'h7FFFFFC, NO_ERR, 31'h6,
        8'd255, 27'h4000004, 1'b1, INF_ERR, 3, 0);
    run("denormal", 1'b0, 8'd1, 28'h0100000, NO_ERR, 31'h7,
        8'd0, 27'h0100000, 1'b0, NO_ERR, 3, 0);
    run("denorm_round_up", 1'b0, 8'd1, 28'h3FFFFFC, NO_ERR, 31'h8,
        8'd1, 27'h4000004, 1'b0, NO_ERR, 3, 0);
    run("zero_sum", 1'b1, 8'd5, 28'h0000000, NO_ERR, 31'h9,
        8'd5, 27'h0000000, 1'b0, ZERO_ERR, 1, 0);
    run("nan_pass_bp", 1'b1, 8'd200, 28'h0ABCDEF, NAN_ERR, 31'h12345,
        8'd200, 27'h0ABCDEF, 1'b0, NAN_ERR, 1, 5);
    run("sticky_round", 1'b0, 8'd100, 28'h800000D, NO_ERR, 31'hA,
        8'd101, 27'h400000F, 1'b0, NO_ERR, 3, 0);

    // Reset during NORM of the cancellation case
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sign_i    = 1'b0;
    exp_i     = 8'd130;
    sum_i     = 28'h0000008;
    err_i     = NO_ERR;
    nz_op_i   = 31'hB;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.err", 64'(err_o), 64'(ZERO_ERR));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.idle_valid", 64'(out_valid), 64'd0);
    run("after_rst", 1'b1, 8'd127, 28'h8000000, NO_ERR, 31'hC,
        8'd128, 27'h4000000, 1'b0, NO_ERR, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
